// File: rtl/crc_checker.sv
// Serial CRC frame checker: payload MSB-first followed by its CRC. A delay line holds
// back the trailing CRC_SIZE bits so that only payload reaches the engine.
module crc_checker #(
  parameter int                  CRC_SIZE    = 16,
  parameter logic [CRC_SIZE-1:0] INITIAL_VAL = 16'hFFFF,
  parameter logic [CRC_SIZE-1:0] CRC_POLY    = 16'h1021,
  parameter logic [CRC_SIZE-1:0] FINAL_XOR   = 16'h0000,
  parameter int                  CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data,
  input  logic                 valid,
  input  logic                 sof,
  input  logic                 eof,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_ok,
  output logic                 crc_err,
  output logic                 short_frame,
  output logic                 abort,
  output logic [CRC_SIZE-1:0]  rx_crc,
  output logic [CRC_SIZE-1:0]  calc_crc,
  output logic [CNT_WIDTH-1:0] frame_bits
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t               state_reg, state_next;
  logic [CRC_SIZE-1:0]  delay_reg, crc_reg, rx_crc_reg, calc_crc_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 done_reg, abort_reg, ok_reg, err_reg, short_reg;

  logic                 take, frame_full, feed_bit;
  logic [CRC_SIZE-1:0]  delay_shifted, delay_after, crc_stepped, crc_after, calc_after;
  logic [CNT_WIDTH-1:0] count_after;

  // Bits are consumed when a frame is open, or when they open one.
  assign take = valid && (sof || state_reg != IDLE);

  generate
    if (CRC_SIZE > 1) begin : g_shift
      assign delay_shifted = {delay_reg[CRC_SIZE-2:0], data};
    end else begin : g_shift1
      assign delay_shifted = data;
    end
  endgenerate

  // Engine input is the bit falling out of the delay line.
  assign feed_bit       = delay_reg[CRC_SIZE-1] ^ crc_reg[CRC_SIZE-1];
  assign crc_stepped[0] = feed_bit;
  genvar gi;
  generate
    for (gi = 1; gi < CRC_SIZE; gi++) begin : g_step
      assign crc_stepped[gi] = crc_reg[gi-1] ^ (feed_bit & CRC_POLY[gi]);
    end
  endgenerate

  always_comb begin
    crc_after   = crc_reg;
    delay_after = delay_shifted;
    count_after = (&count_reg) ? count_reg : count_reg + CNT_WIDTH'(1);
    if (sof) begin
      crc_after   = INITIAL_VAL;
      delay_after = CRC_SIZE'(data);
      count_after = CNT_WIDTH'(1);
    end else if (state_reg == RUN) begin
      crc_after = crc_stepped;
    end
  end

  assign frame_full = (count_after >= CNT_WIDTH'(CRC_SIZE));
  assign calc_after = crc_after ^ FINAL_XOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (take) begin
      if (eof) begin
        state_next = IDLE;
      end else if (frame_full) begin
        state_next = RUN;
      end else begin
        state_next = FILL;
      end
    end
  end

  always_comb begin
    busy        = (state_reg != IDLE);
    done        = done_reg;
    abort       = abort_reg;
    crc_ok      = ok_reg;
    crc_err     = err_reg;
    short_frame = short_reg;
    rx_crc      = rx_crc_reg;
    calc_crc    = calc_crc_reg;
    frame_bits  = count_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      delay_reg    <= '0;
      crc_reg      <= INITIAL_VAL;
      count_reg    <= '0;
      done_reg     <= 1'b0;
      abort_reg    <= 1'b0;
      ok_reg       <= 1'b0;
      err_reg      <= 1'b0;
      short_reg    <= 1'b0;
      rx_crc_reg   <= '0;
      calc_crc_reg <= '0;
    end else begin
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;
      if (take) begin
        crc_reg   <= crc_after;
        delay_reg <= delay_after;
        count_reg <= count_after;
        if (sof) begin
          abort_reg    <= (state_reg != IDLE);
          ok_reg       <= 1'b0;
          err_reg      <= 1'b0;
          short_reg    <= 1'b0;
          rx_crc_reg   <= '0;
          calc_crc_reg <= '0;
        end
        if (eof) begin
          done_reg <= 1'b1;
          if (frame_full) begin
            rx_crc_reg   <= delay_after;
            calc_crc_reg <= calc_after;
            ok_reg       <= (delay_after == calc_after);
            err_reg      <= (delay_after != calc_after);
            short_reg    <= 1'b0;
          end else begin
            ok_reg    <= 1'b0;
            err_reg   <= 1'b1;
            short_reg <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_checker.sv
// Directed and randomized frames for crc_checker, checked against a plain bitwise
// polynomial-division model of CRC-16/CCITT-FALSE.
module tb_crc_checker;

  localparam int          W    = 16;
  localparam logic [15:0] INIT = 16'hFFFF;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] FX   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, data, valid, sof, eof;
  logic        busy, done, crc_ok, crc_err, short_frame, abort;
  logic [15:0] rx_crc, calc_crc, frame_bits;

  int checks   = 0;
  int failures = 0;
  bit frame_q[$];

  crc_checker #(
    .CRC_SIZE(W), .INITIAL_VAL(INIT), .CRC_POLY(POLY), .FINAL_XOR(FX), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .sof(sof), .eof(eof),
    .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
    .short_frame(short_frame), .abort(abort), .rx_crc(rx_crc), .calc_crc(calc_crc),
    .frame_bits(frame_bits)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Textbook MSB-first CRC over the first n bits of frame_q.
  function automatic logic [15:0] model_crc(int n);
    logic [15:0] c;
    c = INIT;
    for (int i = 0; i < n; i++) begin
      if (frame_q[i] ^ c[15]) c = (c << 1) ^ POLY;
      else c = c << 1;
    end
    return c ^ FX;
  endfunction

  task automatic push_word(logic [15:0] v, int w);
    for (int k = w - 1; k >= 0; k--) frame_q.push_back(v[k]);
  endtask

  task automatic build_std();
    frame_q.delete();
    for (int k = 0; k < 9; k++) push_word(16'h0031 + 16'(k), 8);
    push_word(16'h29B1, 16);
  endtask

  // Drives the first n bits of frame_q (sof on bit 0); optional eof and result check.
  task automatic send_bits(string tag, int n, bit with_eof, int gap_pct, bit expect_abort);
    int          spurious;
    logic        e_ok, e_err, e_short;
    logic [15:0] e_rx, e_calc;
    spurious = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        while (int'($urandom_range(99)) < gap_pct) begin
          valid = 1'b0; data = 1'($urandom); sof = 1'($urandom); eof = 1'($urandom);
          @(negedge clk);
          if (done !== 1'b0 || abort !== 1'b0) spurious++;
        end
      end
      valid = 1'b1; data = frame_q[i]; sof = (i == 0); eof = with_eof && (i == n - 1);
      @(negedge clk);
      if (i == 0) check({tag, ".abort"}, 32'(abort), 32'(expect_abort));
      else if (abort !== 1'b0) spurious++;
      if (!(with_eof && i == n - 1) && done !== 1'b0) spurious++;
    end
    check({tag, ".no_early_pulse"}, spurious, 0);
    if (with_eof) begin
      if (n >= W) begin
        e_rx = '0;
        for (int k = n - W; k < n; k++) e_rx = {e_rx[14:0], frame_q[k]};
        e_calc  = model_crc(n - W);
        e_ok    = (e_rx == e_calc);
        e_err   = !e_ok;
        e_short = 1'b0;
      end else begin
        e_rx = '0; e_calc = '0; e_ok = 1'b0; e_err = 1'b1; e_short = 1'b1;
      end
      check({tag, ".done"}, 32'(done), 1);
      check({tag, ".busy"}, 32'(busy), 0);
      check({tag, ".crc_ok"}, 32'(crc_ok), 32'(e_ok));
      check({tag, ".crc_err"}, 32'(crc_err), 32'(e_err));
      check({tag, ".short"}, 32'(short_frame), 32'(e_short));
      check({tag, ".rx_crc"}, 32'(rx_crc), 32'(e_rx));
      check({tag, ".calc_crc"}, 32'(calc_crc), 32'(e_calc));
      check({tag, ".frame_bits"}, 32'(frame_bits), n);
      $display("frame %s bits=%0d rx=%h calc=%h ok=%b err=%b short=%b",
               tag, n, rx_crc, calc_crc, crc_ok, crc_err, short_frame);
    end else begin
      $display("partial %s bits=%0d busy=%b", tag, n, busy);
    end
    valid = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic idle_check(string tag);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 32'(done), 0);
  endtask

  initial begin
    int          spur, plen, nbits, idx;
    logic [15:0] crc;
    rst = 1'b1; data = 1'b0; valid = 1'b0; sof = 1'b0; eof = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    check("reset.flags", {28'd0, crc_ok, crc_err, short_frame, abort}, 0);
    check("reset.rx_crc", 32'(rx_crc), 0);
    check("reset.calc_crc", 32'(calc_crc), 0);
    check("reset.frame_bits", 32'(frame_bits), 0);
    rst = 1'b0;

    // Stray bits and eof while idle must be ignored.
    spur = 0;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; sof = 1'b0; eof = 1'($urandom); data = 1'($urandom);
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) spur++;
    end
    valid = 1'b0; eof = 1'b0;
    check("idle_junk.ignored", spur, 0);
    check("idle_junk.frame_bits", 32'(frame_bits), 0);

    build_std();
    send_bits("std", 88, 1'b1, 0, 1'b0);
    check("std.calc_const", 32'(calc_crc), 32'h29B1);
    check("std.ok_const", 32'(crc_ok), 1);
    idle_check("std");

    build_std();
    frame_q[5] = ~frame_q[5];
    send_bits("flip5", 88, 1'b1, 0, 1'b0);
    check("flip5.rx_const", 32'(rx_crc), 32'h29B1);
    check("flip5.err_const", 32'(crc_err), 1);
    idle_check("flip5");

    frame_q.delete();
    push_word(16'hFFFF, 16);
    send_bits("empty", 16, 1'b1, 0, 1'b0);
    check("empty.ok_const", 32'(crc_ok), 1);
    idle_check("empty");

    frame_q.delete();
    push_word(16'($urandom), 10);
    send_bits("short10", 10, 1'b1, 0, 1'b0);
    check("short10.short_const", 32'(short_frame), 1);

    // 1-bit frame back-to-back with the previous one.
    frame_q.delete();
    frame_q.push_back(1'b1);
    send_bits("onebit", 1, 1'b1, 0, 1'b0);
    idle_check("onebit");

    build_std();
    send_bits("gaps", 88, 1'b1, 40, 1'b0);
    check("gaps.ok_const", 32'(crc_ok), 1);
    idle_check("gaps");

    for (int f = 0; f < 12; f++) begin
      frame_q.delete();
      if (f % 4 == 3) begin
        nbits = $urandom_range(1, 15);
        for (int k = 0; k < nbits; k++) frame_q.push_back(1'($urandom));
      end else begin
        plen = $urandom_range(0, 40);
        for (int k = 0; k < plen; k++) frame_q.push_back(1'($urandom));
        crc = model_crc(plen);
        push_word(crc, 16);
        if ($urandom_range(2) == 0) begin
          idx = $urandom_range(frame_q.size() - 1);
          frame_q[idx] = ~frame_q[idx];
        end
      end
      send_bits($sformatf("rnd%0d", f), frame_q.size(), 1'b1,
                ($urandom_range(1) == 1) ? 30 : 0, 1'b0);
      if ($urandom_range(1) == 1) idle_check($sformatf("rnd%0d", f));
    end
    idle_check("rnd_end");

    // New sof at bit 40 abandons frame A.
    build_std();
    send_bits("abortA", 40, 1'b0, 0, 1'b0);
    send_bits("abortB", 88, 1'b1, 0, 1'b1);
    check("abortB.ok_const", 32'(crc_ok), 1);
    idle_check("abortB");

    // Reset at bit 30 overrides active inputs and yields no done or abort.
    build_std();
    send_bits("rstA", 30, 1'b0, 0, 1'b0);
    rst = 1'b1; valid = 1'b1; sof = 1'b1; eof = 1'b1; data = 1'b1;
    @(negedge clk);
    check("rst_mid.busy", 32'(busy), 0);
    check("rst_mid.pulses", {30'd0, done, abort}, 0);
    check("rst_mid.flags", {29'd0, crc_ok, crc_err, short_frame}, 0);
    check("rst_mid.data", {rx_crc, calc_crc}, 0);
    check("rst_mid.frame_bits", 32'(frame_bits), 0);
    rst = 1'b0; valid = 1'b0; sof = 1'b0; eof = 1'b0;
    spur = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || abort !== 1'b0 || busy !== 1'b0) spur++;
    end
    check("rst_mid.quiet", spur, 0);

    build_std();
    send_bits("post_rst", 88, 1'b1, 0, 1'b0);
    idle_check("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
